// File: rtl/tlu_dut_rx_pkg.sv
// Shared types and sizes for the TLU DUT-side receiver.
// State encoding plus trigger-ID and shift-frame widths.
package tlu_dut_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_RELEASE = 2'd1,
        ST_SHIFT        = 2'd2,
        ST_HOLD         = 2'd3
    } tlu_state_t;

    localparam int TLU_ID_BITS    = 15;
    localparam int TLU_SHIFT_BITS = 16;

endpackage

// File: rtl/tlu_dut_rx_sync.sv
// Two-flop synchronizer with rising-edge detect for one asynchronous TLU line.
// Latency: 2 clk_i cycles to sync_o, rise_o is a one-cycle pulse alongside.
// Backpressure: none, free-running.
module tlu_dut_rx_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/tlu_dut_rx.sv
// DUT-side TLU receiver: trigger handshake, serial ID readout, valid/ready trigger stream.
// Latency: busy one cycle after synced trigger edge; ID valid after 16 TLU_CLOCK periods (MODE 1).
// Backpressure: TRIG_VALID/TRIG_ID hold until TRIG_READY; TLU_BUSY holds while DUT_BUSY. Optional TRIG_TS via TLU_DUT_RX_TIMESTAMP_EN.
module tlu_dut_rx
    import tlu_dut_rx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 16'hFFFF
) (
    input  logic                   SYS_CLK,
    input  logic                   SYS_RST_N,
    input  logic                   TLU_TRIGGER,
    input  logic                   TLU_RESET,
    output logic                   TLU_BUSY,
    output logic                   TLU_CLOCK,
    input  logic                   ENABLE,
    input  logic                   MODE,
    input  logic                   DUT_BUSY,
    output logic [TLU_ID_BITS-1:0] TRIG_ID,
    output logic                   TRIG_VALID,
    input  logic                   TRIG_READY,
`ifdef TLU_DUT_RX_TIMESTAMP_EN
    output logic [31:0]            TRIG_TS,
`endif
    output logic [31:0]            TRIG_CNT,
    output logic [7:0]             ERR_CNT,
    output logic                   TIMEOUT_ERR
);

    // CLK_DIV must be >= 3 so the synchronizer delay fits inside one high phase.
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  BIT_LAST = 4'(TLU_SHIFT_BITS - 1);

    logic trig_lvl;
    logic trig_rise;
    logic rst_lvl_unused;
    logic rst_rise;

    tlu_dut_rx_sync u_sync_trig (
        .clk_i   (SYS_CLK),
        .rst_n_i (SYS_RST_N),
        .async_i (TLU_TRIGGER),
        .sync_o  (trig_lvl),
        .rise_o  (trig_rise)
    );

    tlu_dut_rx_sync u_sync_rst (
        .clk_i   (SYS_CLK),
        .rst_n_i (SYS_RST_N),
        .async_i (TLU_RESET),
        .sync_o  (rst_lvl_unused),
        .rise_o  (rst_rise)
    );

    tlu_state_t             state_q;
    logic                   busy_q;
    logic                   clk_q;
    logic                   valid_q;
    logic [TLU_ID_BITS-1:0] id_q;
    logic [TLU_ID_BITS-1:0] sr_q;
    logic [31:0]            cnt_q;
    logic [7:0]             err_q;
    logic                   tmo_err_q;
    logic [15:0]            tmo_q;
    logic [7:0]             div_q;
    logic [3:0]             bit_q;

    logic start;
    logic accept;

    assign start  = (state_q == ST_IDLE) & ENABLE & trig_rise;
    assign accept = valid_q & TRIG_READY;

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            clk_q     <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            tmo_err_q <= 1'b0;
            tmo_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
        end else begin
            tmo_err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        tmo_q  <= '0;
                        if (MODE) begin
                            state_q <= ST_WAIT_RELEASE;
                        end else begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                            id_q    <= cnt_q[TLU_ID_BITS-1:0];
                        end
                    end
                end

                ST_WAIT_RELEASE: begin
                    if (!trig_lvl) begin
                        state_q <= ST_SHIFT;
                        clk_q   <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                        if (err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end

                ST_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (clk_q) begin
                            // Last high cycle: the TLU's bit has had the full phase to settle.
                            clk_q <= 1'b0;
                            if (bit_q != 4'd0) begin
                                sr_q <= {sr_q[TLU_ID_BITS-2:0], trig_lvl};
                            end
                        end else if (bit_q == BIT_LAST) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                            id_q    <= sr_q;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            clk_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (!valid_q || TRIG_READY) begin
                        valid_q <= 1'b0;
                        if (!DUT_BUSY) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase

            // Counter clear is placed last so it overrides a same-cycle increment.
            if (rst_rise) begin
                cnt_q <= '0;
                err_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

`ifdef TLU_DUT_RX_TIMESTAMP_EN
    logic [31:0] ts_free_q;
    logic [31:0] ts_q;

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            ts_free_q <= '0;
            ts_q      <= '0;
        end else begin
            ts_free_q <= ts_free_q + 32'd1;
            if (start) begin
                ts_q <= ts_free_q;
            end
        end
    end

    assign TRIG_TS = ts_q;
`endif

    assign TLU_BUSY    = busy_q;
    assign TLU_CLOCK   = clk_q;
    assign TRIG_VALID  = valid_q;
    assign TRIG_ID     = id_q;
    assign TRIG_CNT    = cnt_q;
    assign ERR_CNT     = err_q;
    assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Directed bench for tlu_dut_rx: table of trigger transactions plus hand-written corner sequences.
module tb_tlu_dut_rx;

    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 64;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N;
    logic        TLU_TRIGGER;
    logic        TLU_RESET;
    logic        TLU_BUSY;
    logic        TLU_CLOCK;
    logic        ENABLE;
    logic        MODE;
    logic        DUT_BUSY;
    logic [14:0] TRIG_ID;
    logic        TRIG_VALID;
    logic        TRIG_READY;
    logic [31:0] TRIG_CNT;
    logic [7:0]  ERR_CNT;
    logic        TIMEOUT_ERR;
`ifdef TLU_DUT_RX_TIMESTAMP_EN
    logic [31:0] TRIG_TS;
`endif

    int checks = 0;
    int errors = 0;

    always #5 SYS_CLK = ~SYS_CLK;

    tlu_dut_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .SYS_CLK     (SYS_CLK),
        .SYS_RST_N   (SYS_RST_N),
        .TLU_TRIGGER (TLU_TRIGGER),
        .TLU_RESET   (TLU_RESET),
        .TLU_BUSY    (TLU_BUSY),
        .TLU_CLOCK   (TLU_CLOCK),
        .ENABLE      (ENABLE),
        .MODE        (MODE),
        .DUT_BUSY    (DUT_BUSY),
        .TRIG_ID     (TRIG_ID),
        .TRIG_VALID  (TRIG_VALID),
        .TRIG_READY  (TRIG_READY),
`ifdef TLU_DUT_RX_TIMESTAMP_EN
        .TRIG_TS     (TRIG_TS),
`endif
        .TRIG_CNT    (TRIG_CNT),
        .ERR_CNT     (ERR_CNT),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    typedef struct {
        logic        clr;
        logic        mode;
        logic [14:0] id;
        int          rdy_dly;
        int          busy_len;
        logic        en_drop;
        logic [14:0] exp_id;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, TLU_BUSY, 0);
        check({tag, "_tluclk"}, TLU_CLOCK, 0);
        check({tag, "_valid"}, TRIG_VALID, 0);
        check({tag, "_id"}, TRIG_ID, 0);
        check({tag, "_cnt"}, TRIG_CNT, 0);
        check({tag, "_err"}, ERR_CNT, 0);
        check({tag, "_tmo"}, TIMEOUT_ERR, 0);
    endtask

    task automatic wait_valid(input int limit, output logic got);
        got = 1'b0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge SYS_CLK);
            if (TRIG_VALID) got = 1'b1;
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic        got;
        logic        stable;
        logic        held;
        logic        prev;
        logic [14:0] sh;
        int          edges;
        int          hi;
        int          first;
        int          last;

        if (v.clr) begin
            TLU_RESET = 1'b1;
            repeat (4) @(negedge SYS_CLK);
            TLU_RESET = 1'b0;
            check("clr_cnt", TRIG_CNT, 0);
            check("clr_err", ERR_CNT, 0);
        end
        MODE        = v.mode;
        TRIG_READY  = 1'b0;
        DUT_BUSY    = (v.busy_len > 0);
        TLU_TRIGGER = 1'b1;

        if (v.mode) begin
            repeat (5) @(negedge SYS_CLK);
            check("busy_on", TLU_BUSY, 1);
            MODE = ~v.mode;
            if (v.en_drop) ENABLE = 1'b0;
            TLU_TRIGGER = 1'b0;
            // TLU model: new bit after each TLU_CLOCK rise, dummy bit first, then ID MSB first
            sh = v.id; prev = 1'b0; edges = 0; hi = 0; first = 0; last = 0; got = 1'b0;
            for (int c = 0; c < 800 && !got; c++) begin
                @(negedge SYS_CLK);
                if (TRIG_VALID) begin
                    got = 1'b1;
                end else begin
                    if (TLU_CLOCK) hi++;
                    if (TLU_CLOCK && !prev) begin
                        if (edges == 0) begin
                            TLU_TRIGGER = 1'b0;
                            first = c;
                        end else begin
                            TLU_TRIGGER = sh[14];
                            sh = sh << 1;
                        end
                        last = c;
                        edges++;
                    end
                    prev = TLU_CLOCK;
                end
            end
            TLU_TRIGGER = 1'b0;
            check("valid_seen", got, 1);
            check("tluclk_periods", edges, 16);
            check("tluclk_high_cycles", hi, 16 * CLK_DIV);
            check("tluclk_span", last - first, 15 * 2 * CLK_DIV);
        end else begin
            wait_valid(20, got);
            check("valid_seen", got, 1);
            check("busy_on", TLU_BUSY, 1);
            MODE = ~v.mode;
            if (v.en_drop) ENABLE = 1'b0;
            TLU_TRIGGER = 1'b0;
        end

        stable = 1'b1;
        for (int i = 0; i < v.rdy_dly; i++) begin
            @(negedge SYS_CLK);
            if (TRIG_ID !== v.exp_id || TRIG_VALID !== 1'b1) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("trig_id", TRIG_ID, v.exp_id);
        check("trig_valid", TRIG_VALID, 1);
        TRIG_READY = 1'b1;
        @(negedge SYS_CLK);
        TRIG_READY = 1'b0;
        check("valid_drop", TRIG_VALID, 0);
        check("trig_cnt", TRIG_CNT, v.exp_cnt);
        if (v.busy_len > 0) begin
            held = 1'b1;
            for (int i = 0; i < v.busy_len; i++) begin
                if (!TLU_BUSY) held = 1'b0;
                @(negedge SYS_CLK);
            end
            check("busy_held", held, 1);
            DUT_BUSY = 1'b0;
            @(negedge SYS_CLK);
        end
        check("busy_drop", TLU_BUSY, 0);

        if (v.en_drop) begin
            TLU_TRIGGER = 1'b1;
            repeat (10) @(negedge SYS_CLK);
            check("disabled_busy", TLU_BUSY, 0);
            check("disabled_valid", TRIG_VALID, 0);
            TLU_TRIGGER = 1'b0;
            repeat (4) @(negedge SYS_CLK);
            ENABLE = 1'b1;
        end
        repeat (4) @(negedge SYS_CLK);
    endtask

    task automatic clr_with_accept(input logic [31:0] preset);
        logic got;
        force dut.cnt_q = preset;
        @(negedge SYS_CLK);
        release dut.cnt_q;
        MODE        = 1'b0;
        TLU_TRIGGER = 1'b1;
        wait_valid(20, got);
        check("clracc_valid", got, 1);
        TLU_TRIGGER = 1'b0;
        // TLU_RESET edge reaches the logic two cycles later, lined up with the accept
        TLU_RESET = 1'b1;
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        TRIG_READY = 1'b1;
        @(negedge SYS_CLK);
        TRIG_READY = 1'b0;
        TLU_RESET  = 1'b0;
        check("clracc_cnt", TRIG_CNT, 0);
        check("clracc_err", ERR_CNT, 0);
        check("clracc_valid_drop", TRIG_VALID, 0);
        repeat (4) @(negedge SYS_CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int   pulses;
        logic vseen;
        vec_t rv;

        vecs[0] = '{1'b0, 1'b1, 15'h1234, 0,  0,   1'b0, 15'h1234, 32'd1};
        vecs[1] = '{1'b1, 1'b0, 15'h0000, 0,  0,   1'b0, 15'h0000, 32'd1};
        vecs[2] = '{1'b0, 1'b0, 15'h0000, 0,  0,   1'b0, 15'h0001, 32'd2};
        vecs[3] = '{1'b0, 1'b0, 15'h0000, 0,  0,   1'b0, 15'h0002, 32'd3};
        vecs[4] = '{1'b0, 1'b1, 15'h2AD5, 50, 100, 1'b0, 15'h2AD5, 32'd4};
        vecs[5] = '{1'b0, 1'b0, 15'h0000, 3,  0,   1'b0, 15'h0004, 32'd5};
        vecs[6] = '{1'b0, 1'b1, 15'h7FFF, 0,  0,   1'b1, 15'h7FFF, 32'd6};
        vecs[7] = '{1'b0, 1'b1, 15'h0001, 2,  0,   1'b0, 15'h0001, 32'd7};

        SYS_RST_N   = 1'b0;
        TLU_TRIGGER = 1'b0;
        TLU_RESET   = 1'b0;
        ENABLE      = 1'b1;
        MODE        = 1'b0;
        DUT_BUSY    = 1'b0;
        TRIG_READY  = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        check_reset_outputs("reset");
        SYS_RST_N = 1'b1;
        repeat (5) @(negedge SYS_CLK);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Trigger stuck high in MODE 1 must time out once, then be ignored until it falls.
        MODE = 1'b1;
        TLU_TRIGGER = 1'b1;
        pulses = 0;
        vseen  = 1'b0;
        for (int c = 0; c < TIMEOUT + 10; c++) begin
            @(negedge SYS_CLK);
            if (TIMEOUT_ERR) pulses++;
            if (TRIG_VALID) vseen = 1'b1;
        end
        check("tmo_pulses", pulses, 1);
        check("tmo_err_cnt", ERR_CNT, 1);
        check("tmo_busy", TLU_BUSY, 0);
        check("tmo_no_valid", vseen, 0);
        check("tmo_tluclk", TLU_CLOCK, 0);
        repeat (10) @(negedge SYS_CLK);
        check("stuck_high_ignored", TLU_BUSY, 0);
        TLU_TRIGGER = 1'b0;
        repeat (4) @(negedge SYS_CLK);

        // Accept at the top of the count wraps to zero.
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge SYS_CLK);
        release dut.cnt_q;
        rv = '{1'b0, 1'b0, 15'h0000, 0, 0, 1'b0, 15'h7FFF, 32'd0};
        run_txn(rv);

        clr_with_accept(32'hFFFF_FFFF);
        clr_with_accept(32'd5);

        // Reset in the middle of the ID shift.
        MODE        = 1'b1;
        TLU_TRIGGER = 1'b1;
        repeat (5) @(negedge SYS_CLK);
        TLU_TRIGGER = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge SYS_CLK);
            if (TLU_CLOCK) got = 1'b1;
        end
        check("shift_started", got, 1);
        repeat (20) @(negedge SYS_CLK);
        SYS_RST_N = 1'b0;
        #1;
        check_reset_outputs("midshift");
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        vseen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge SYS_CLK);
            if (TRIG_VALID || TLU_BUSY || TIMEOUT_ERR) vseen = 1'b1;
        end
        check("post_reset_quiet", vseen, 0);
        rv = '{1'b0, 1'b1, 15'h0ABC, 1, 0, 1'b0, 15'h0ABC, 32'd1};
        run_txn(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlu_dut_rx.md
TLU_DUT_RX -- requirements
Module: tlu_dut_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: TLU_CLOCK half-period in SYS_CLK cycles; legal range 3..255.
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF: maximum SYS_CLK cycles spent waiting for trigger release.
REQ-003 SHALL have port SYS_CLK, input, 1: the only clock.
REQ-004 SHALL have port SYS_RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port TLU_TRIGGER, input, 1: asynchronous trigger, then serial ID bit line from the TLU.
REQ-006 SHALL have port TLU_RESET, input, 1: asynchronous counter-reset request from the TLU.
REQ-007 SHALL have port TLU_BUSY, output, 1: busy indication to the TLU, registered.
REQ-008 SHALL have port TLU_CLOCK, output, 1: ID shift clock to the TLU, registered.
REQ-009 SHALL have ports ENABLE, input, 1, and MODE, input, 1: MODE 0 = trigger only, MODE 1 = handshake with ID readout.
REQ-010 SHALL have port DUT_BUSY, input, 1: local request to keep TLU_BUSY asserted.
REQ-011 SHALL have ports TRIG_ID, output, 15; TRIG_VALID, output, 1; TRIG_READY, input, 1: valid/ready trigger stream.
REQ-012 SHALL have ports TRIG_CNT, output, 32; ERR_CNT, output, 8; TIMEOUT_ERR, output, 1 (one-cycle pulse).

Function
REQ-013 SHALL pass TLU_TRIGGER and TLU_RESET through 2-FF synchronizers; all logic SHALL use only the synchronized versions.
REQ-014 SHALL implement the states IDLE, WAIT_RELEASE, SHIFT and HOLD.
REQ-015 IDLE: with ENABLE=1, on a rising edge of the synchronized trigger, SHALL go to WAIT_RELEASE if MODE=1, else to HOLD; TLU_BUSY SHALL go high the next cycle.
REQ-016 IDLE SHALL ignore a trigger that is already high when entering IDLE; only rising edges start a transaction.
REQ-017 WAIT_RELEASE: when the synchronized trigger is low, SHALL go to SHIFT.
REQ-018 WAIT_RELEASE: after TIMEOUT cycles with the trigger still high, SHALL pulse TIMEOUT_ERR, increment ERR_CNT (saturating at 255), drop TLU_BUSY and go to IDLE.
REQ-019 SHIFT: SHALL generate 16 TLU_CLOCK periods, each CLK_DIV cycles high then CLK_DIV cycles low, starting high.
REQ-020 SHIFT: SHALL sample the synchronized trigger in the last cycle of each high phase.
REQ-021 SHIFT: SHALL discard sample 0 and shift samples 1..15 in MSB first into TRIG_ID; after the last low phase SHALL go to HOLD.
REQ-022 In MODE 0, TRIG_ID SHALL equal TRIG_CNT[14:0] captured at trigger detection.
REQ-023 HOLD: TRIG_VALID SHALL be high and TRIG_ID stable until TRIG_READY is high.
REQ-024 HOLD: on handshake completion with DUT_BUSY=0, SHALL go to IDLE; otherwise SHALL wait for DUT_BUSY=0. TLU_BUSY SHALL drop the cycle after leaving HOLD.
REQ-025 TRIG_CNT SHALL increment on each TRIG_VALID&TRIG_READY and wrap at 2^32.
REQ-026 A rising edge of synchronized TLU_RESET SHALL clear TRIG_CNT and ERR_CNT the next cycle without disturbing the FSM; if simultaneous with an increment, clear SHALL win.
REQ-027 Deasserting ENABLE mid-transaction SHALL NOT abort it; the block SHALL stay in IDLE afterwards.
REQ-028 MODE SHALL be sampled only on leaving IDLE.

Reset
REQ-029 SYS_RST_N low SHALL force: state IDLE, TLU_BUSY=0, TLU_CLOCK=0, TRIG_VALID=0, TRIG_ID=0, TRIG_CNT=0, ERR_CNT=0, TIMEOUT_ERR=0, synchronizers=0.
REQ-030 A reset asserted mid-transaction SHALL abandon the transaction with no output pulse.

Configuration
REQ-031 Macro TLU_DUT_RX_TIMESTAMP_EN defined: SHALL add output TRIG_TS [31:0], a free-running SYS_CLK counter captured at trigger detection and held with TRIG_ID under the same valid/ready rule.
REQ-032 Macro TLU_DUT_RX_TIMESTAMP_EN undefined: SHALL have no TRIG_TS port and no timestamp logic.

Structure
REQ-033 Package tlu_dut_rx_pkg SHALL hold the state enumeration, TLU_ID_BITS=15 and TLU_SHIFT_BITS=16.
REQ-034 SHALL instantiate sub-module tlu_dut_rx_sync (2-FF synchronizer with rising-edge detect) twice, for TLU_TRIGGER and TLU_RESET.

Verification
REQ-035 MODE=1, CLK_DIV=4, TLU model sends ID 15'h1234 -> 16 TLU_CLOCK periods of 8 cycles, TRIG_ID=15'h1234, TRIG_VALID high, TRIG_CNT=1.
REQ-036 MODE=1, trigger held high for TIMEOUT+10 cycles -> one TIMEOUT_ERR pulse, ERR_CNT=1, TLU_BUSY low, no TRIG_VALID.
REQ-037 MODE=0, three triggers with TRIG_READY=1 -> TRIG_ID 0, 1, 2; TLU_BUSY drops after each.
REQ-038 TRIG_READY=0 for 50 cycles, DUT_BUSY high for 100 -> TRIG_ID stable; TLU_BUSY held until DUT_BUSY falls.
REQ-039 TLU_RESET pulse coincident with an accept, TRIG_CNT=32'hFFFFFFFF -> TRIG_CNT=0; separately, an accept at 32'hFFFFFFFF wraps to 0.
REQ-040 SYS_RST_N asserted mid-SHIFT -> all outputs at reset values; the next trigger completes normally.
